// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: operation encodings, bus widths,
// sequencer state encoding and the per-op decode/extension helpers.
package mem_stage_pkg;

   localparam int REG_W      = 32;  // RegBus
   localparam int REG_ADDR_W = 5;   // RegAddrBus
   localparam int MEM_ADDR_W = 32;  // MemAddrBus

   localparam logic [7:0] EXE_NOP_OP = 8'h00;
   localparam logic [7:0] EXE_ADD_OP = 8'h20;
   localparam logic [7:0] EXE_LB_OP  = 8'he0;
   localparam logic [7:0] EXE_LH_OP  = 8'he1;
   localparam logic [7:0] EXE_LW_OP  = 8'he3;
   localparam logic [7:0] EXE_LBU_OP = 8'he4;
   localparam logic [7:0] EXE_LHU_OP = 8'he5;
   localparam logic [7:0] EXE_SB_OP  = 8'he8;
   localparam logic [7:0] EXE_SH_OP  = 8'he9;
   localparam logic [7:0] EXE_SW_OP  = 8'heb;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_ACCESS,
      MEM_DONE
   } mem_state_e;

   function automatic logic op_is_load(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
             (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

   // Index of the final byte of the transfer (byte count N minus one).
   function automatic logic [1:0] op_last_byte(input logic [7:0] op);
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
         EXE_LW_OP, EXE_SW_OP:             return 2'd3;
         default:                          return 2'd0;
      endcase
   endfunction

   function automatic logic [REG_W-1:0] load_extend(input logic [7:0] op,
                                                    input logic [REG_W-1:0] b);
      case (op)
         EXE_LB_OP:  return {{24{b[7]}}, b[7:0]};
         EXE_LBU_OP: return {24'h0, b[7:0]};
         EXE_LH_OP:  return {{16{b[15]}}, b[15:0]};
         EXE_LHU_OP: return {16'h0, b[15:0]};
         EXE_LW_OP:  return b;
         default:    return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-serial transfer sequencer for the MEM stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a transfer (only honoured in MEM_IDLE)
//   is_store        latched op is a store
//   last_k          index of final byte (N-1)
//   addr, data      latched base address and store data
//   ram_ack         memory accepted/completed the current byte
//   ram_req/we/addr/dout  byte request to memory
//   state, k        current FSM state and byte index
//   byte_ack        pulse: byte k completed this cycle
module mem_byte_seq
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [1:0]            last_k,
   input  logic [MEM_ADDR_W-1:0] addr,
   input  logic [REG_W-1:0]      data,
   input  logic                  ram_ack,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [MEM_ADDR_W-1:0] ram_addr,
   output logic [7:0]            ram_dout,
   output mem_state_e            state,
   output logic [1:0]            k,
   output logic                  byte_ack
);

   mem_state_e state_nx;
   logic [1:0] k_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MEM_IDLE;
         k     <= 2'd0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
      end
   end

   always_comb begin
      state_nx = state;
      k_nx     = k;
      ram_req  = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_dout = '0;
      byte_ack = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (start) begin
               state_nx = MEM_ACCESS;
               k_nx     = 2'd0;
            end
         end
         MEM_ACCESS: begin
            ram_req  = 1'b1;
            ram_we   = is_store;
            // 32-bit add wraps naturally past 0xFFFFFFFF
            ram_addr = addr + {30'h0, k};
            ram_dout = data[{k, 3'b000} +: 8];
            if (ram_ack) begin
               byte_ack = 1'b1;
               if (k == last_k) begin
                  state_nx = MEM_DONE;
                  k_nx     = 2'd0;
               end else begin
                  k_nx = k + 2'd1;
               end
            end
         end
         MEM_DONE: state_nx = MEM_IDLE;
         default:  state_nx = MEM_IDLE;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V core (between EX_MEM and MEM_WB).
// ALU results pass straight through; loads/stores run as byte-serial
// little-endian transfers on the 8-bit memory port while the pipe stalls.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_wd/wreg/wdata/aluop/mem_addr  operation from EX_MEM
//   ram_req/we/addr/dout, ram_din/ack 8-bit memory port
//   wb_wd/wreg/wdata                  result to MEM_WB
//   stallreq_mem                      stall request to ctrl
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ALUOP_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] mem_wd,
   input  logic                  mem_wreg,
   input  logic [REG_W-1:0]      mem_wdata,
   input  logic [ALUOP_W-1:0]    mem_aluop,
   input  logic [MEM_ADDR_W-1:0] mem_mem_addr,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [MEM_ADDR_W-1:0] ram_addr,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din,
   input  logic                  ram_ack,
   output logic [REG_ADDR_W-1:0] wb_wd,
   output logic                  wb_wreg,
   output logic [REG_W-1:0]      wb_wdata,
   output logic                  stallreq_mem
);

   logic [7:0]            op_in;
   logic                  in_mem_op;
   logic                  start;
   logic [MEM_ADDR_W-1:0] addr_q;
   logic [REG_W-1:0]      data_q;
   logic [REG_W-1:0]      buf_q;
   logic [REG_ADDR_W-1:0] wd_q;
   logic [7:0]            op_q;
   mem_state_e            state;
   logic [1:0]            k;
   logic                  byte_ack;

   assign op_in     = 8'(mem_aluop);
   assign in_mem_op = op_is_load(op_in) || op_is_store(op_in);
   assign start     = (state == MEM_IDLE) && in_mem_op && !rst;

   // EX_MEM is held during the stall, but the latched copy keeps the
   // transfer independent of whatever the inputs do meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         buf_q  <= '0;
         wd_q   <= '0;
         op_q   <= '0;
      end else begin
         if (start) begin
            addr_q <= mem_mem_addr;
            data_q <= mem_wdata;
            wd_q   <= mem_wd;
            op_q   <= op_in;
            buf_q  <= '0;
         end
         if (byte_ack && op_is_load(op_q))
            buf_q[{k, 3'b000} +: 8] <= ram_din;
      end
   end

   mem_byte_seq u_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .is_store (op_is_store(op_q)),
      .last_k   (op_last_byte(op_q)),
      .addr     (addr_q),
      .data     (data_q),
      .ram_ack  (ram_ack),
      .ram_req  (ram_req),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_dout (ram_dout),
      .state    (state),
      .k        (k),
      .byte_ack (byte_ack)
   );

   always_comb begin
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
      stallreq_mem = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (!rst) begin
               wb_wd = mem_wd;
               if (in_mem_op) begin
                  stallreq_mem = 1'b1;
               end else begin
                  wb_wreg  = mem_wreg;
                  wb_wdata = mem_wdata;
               end
            end
         end
         MEM_ACCESS: begin
            wb_wd        = wd_q;
            stallreq_mem = 1'b1;
         end
         MEM_DONE: begin
            wb_wd    = wd_q;
            wb_wreg  = op_is_load(op_q);
            wb_wdata = load_extend(op_q, buf_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic        ram_req, ram_we, ram_ack;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout, ram_din;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        stallreq_mem;

   always #5 clk = ~clk;

   mem_stage #(.ALUOP_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .mem_aluop    (mem_aluop),
      .mem_mem_addr (mem_mem_addr),
      .ram_req      (ram_req),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din),
      .ram_ack      (ram_ack),
      .wb_wd        (wb_wd),
      .wb_wreg      (wb_wreg),
      .wb_wdata     (wb_wdata),
      .stallreq_mem (stallreq_mem)
   );

   // Byte memory model (aliased on low 12 address bits), written only by the initial process
   logic [7:0]  mem [0:4095];
   int unsigned wait_cfg = 0;
   int unsigned wcnt;

   assign ram_ack = ram_req && (wcnt >= wait_cfg);
   assign ram_din = ram_req ? mem[ram_addr[11:0]] : 8'h00;

   always @(posedge clk) begin
      if (rst)                    wcnt <= 0;
      else if (ram_req && !ram_ack) wcnt <= wcnt + 1;
      else                        wcnt <= 0;
   end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  data;
   } req_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      int          cycles;
   } wb_t;

   req_t exp_req[$];
   req_t obs_req[$];
   wb_t  exp_wb[$];
   wb_t  obs_wb;
   logic timed_out;
   int   n_vec = 0;
   int   n_err = 0;

   // Present one op after an active edge and run it until the stall drops.
   task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
      int cyc;
      cyc = 0;
      obs_req.delete();
      timed_out    = 1'b0;
      mem_aluop    = op;
      mem_mem_addr = addr;
      mem_wdata    = wdata;
      mem_wd       = wd;
      mem_wreg     = wreg;
      forever begin
         @(negedge clk);
         cyc++;
         if (ram_req && ram_ack) begin
            obs_req.push_back('{ram_we, ram_addr, ram_dout});
            if (ram_we) mem[ram_addr[11:0]] = ram_dout;
         end
         if (!stallreq_mem || cyc >= 40) begin
            timed_out = stallreq_mem;
            obs_wb = '{wb_wd, wb_wreg, wb_wdata, cyc};
            break;
         end
      end
      @(posedge clk);
      #1;
      mem_aluop = EXE_NOP_OP;
      mem_wreg  = 1'b0;
   endtask

   task automatic push_reqs(input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input int n);
      for (int i = 0; i < n; i++)
         exp_req.push_back('{we, addr + 32'(i), data[8*i +: 8]});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_aluop = EXE_ADD_OP; mem_wdata = 32'h55; mem_wd = 5'd3; mem_wreg = 1'b1;
      mem_mem_addr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (wb_wdata !== 32'h0 || wb_wreg !== 1'b0 || wb_wd !== 5'd0) begin
         n_err++;
         $display("FAIL reset_wb got wd=%h wreg=%b wdata=%h exp all zero", wb_wd, wb_wreg, wb_wdata);
      end
      mem_aluop = EXE_LW_OP;
      @(posedge clk);
      #1;
      n_vec++;
      if (ram_req !== 1'b0 || stallreq_mem !== 1'b0) begin
         n_err++;
         $display("FAIL reset_memop got req=%b stall=%b exp 0 0", ram_req, stallreq_mem);
      end
      mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      wb_t ew;
      wait_cfg = 0;
      exp_wb.push_back('{5'd5, 1'b1, 32'h1234, 1});
      drive_op(EXE_ADD_OP, 32'h0, 32'h1234, 5'd5, 1'b1);
      ew = exp_wb.pop_front();
      n_vec++;
      if (obs_wb !== ew) begin
         n_err++;
         $display("FAIL add_wb got wd=%0d wreg=%b wdata=%h cyc=%0d exp wd=%0d wreg=%b wdata=%h cyc=%0d",
                  obs_wb.wd, obs_wb.wreg, obs_wb.wdata, obs_wb.cycles, ew.wd, ew.wreg, ew.wdata, ew.cycles);
      end
      n_vec++;
      if (obs_req.size() != 0) begin
         n_err++;
         $display("FAIL add_noreq got %0d requests exp 0", obs_req.size());
      end
   endtask

   // Each table row: op, addr, store data, wd, wait states, byte count, expected wb
   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  wd;
      int          waits;
      int          n;
      logic [31:0] exp_wdata;
   } vec_t;

   task automatic run_table(input string name, input vec_t tbl[$]);
      foreach (tbl[j]) begin
         vec_t v;
         wb_t  ew;
         logic st;
         v  = tbl[j];
         st = (v.op == EXE_SB_OP) || (v.op == EXE_SH_OP) || (v.op == EXE_SW_OP);
         wait_cfg = v.waits;
         push_reqs(st, v.addr, v.data, v.n);
         exp_wb.push_back('{v.wd, !st, st ? 32'h0 : v.exp_wdata, 2 + v.n * (v.waits + 1)});
         drive_op(v.op, v.addr, v.data, v.wd, 1'b1);
         while (exp_req.size() > 0) begin
            req_t e, r;
            e = exp_req.pop_front();
            n_vec++;
            if (obs_req.size() == 0) begin
               n_err++;
               $display("FAIL %s_req[%0d] got none exp addr=%h", name, j, e.addr);
            end else begin
               r = obs_req.pop_front();
               if (r.we !== e.we || r.addr !== e.addr || (e.we && r.data !== e.data)) begin
                  n_err++;
                  $display("FAIL %s_req[%0d] got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                           name, j, r.we, r.addr, r.data, e.we, e.addr, e.data);
               end
            end
         end
         n_vec++;
         if (obs_req.size() != 0) begin
            n_err++;
            $display("FAIL %s_extra[%0d] got %0d extra requests exp 0", name, j, obs_req.size());
         end
         ew = exp_wb.pop_front();
         n_vec++;
         if (timed_out || obs_wb !== ew) begin
            n_err++;
            $display("FAIL %s_wb[%0d] got wd=%0d wreg=%b wdata=%h cyc=%0d to=%b exp wd=%0d wreg=%b wdata=%h cyc=%0d",
                     name, j, obs_wb.wd, obs_wb.wreg, obs_wb.wdata, obs_wb.cycles, timed_out,
                     ew.wd, ew.wreg, ew.wdata, ew.cycles);
         end
      end
   endtask

   task automatic test_lw();
      vec_t t[$];
      mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
      t.push_back('{EXE_LW_OP, 32'h100, 32'h0, 5'd7, 0, 4, 32'h12345678});
      run_table("lw", t);
   endtask

   task automatic test_extend();
      vec_t t[$];
      mem[12'h007] = 8'h80;
      mem[12'h010] = 8'h01; mem[12'h011] = 8'h80;
      t.push_back('{EXE_LB_OP,  32'h7,  32'h0, 5'd1, 0, 1, 32'hFFFFFF80});
      t.push_back('{EXE_LBU_OP, 32'h7,  32'h0, 5'd2, 0, 1, 32'h00000080});
      t.push_back('{EXE_LH_OP,  32'h10, 32'h0, 5'd3, 0, 2, 32'hFFFF8001});
      t.push_back('{EXE_LHU_OP, 32'h10, 32'h0, 5'd4, 1, 2, 32'h00008001});
      run_table("ext", t);
   endtask

   task automatic test_sh_wait();
      vec_t t[$];
      mem[12'h201] = 8'h00; mem[12'h202] = 8'h00; mem[12'h203] = 8'h00;
      t.push_back('{EXE_SH_OP, 32'h201, 32'hAABBCCDD, 5'd9, 2, 2, 32'h0});
      run_table("sh", t);
      n_vec++;
      if (mem[12'h201] !== 8'hDD || mem[12'h202] !== 8'hCC || mem[12'h203] !== 8'h00) begin
         n_err++;
         $display("FAIL sh_mem got %h %h %h exp dd cc 00", mem[12'h201], mem[12'h202], mem[12'h203]);
      end
   endtask

   task automatic test_wrap();
      vec_t t[$];
      mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h12;
      t.push_back('{EXE_LH_OP, 32'hFFFFFFFF, 32'h0, 5'd11, 0, 2, 32'h00001234});
      run_table("wrap", t);
   endtask

   task automatic test_back_to_back();
      vec_t t[$];
      t.push_back('{EXE_SW_OP, 32'h400, 32'hCAFEBABE, 5'd12, 0, 4, 32'h0});
      t.push_back('{EXE_LW_OP, 32'h400, 32'h0,        5'd13, 0, 4, 32'hCAFEBABE});
      t.push_back('{EXE_SB_OP, 32'h402, 32'h00000011, 5'd14, 1, 1, 32'h0});
      t.push_back('{EXE_LW_OP, 32'h400, 32'h0,        5'd15, 0, 4, 32'hCA11BABE});
      run_table("b2b", t);
   endtask

   task automatic test_rst_mid();
      logic got;
      wait_cfg = 2;
      for (int i = 0; i < 4; i++) mem[12'h300 + 12'(i)] = 8'h00;
      mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h300; mem_wdata = 32'hA1B2C3D4;
      mem_wd = 5'd6; mem_wreg = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (ram_req && ram_ack) begin
            mem[ram_addr[11:0]] = ram_dout;
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL rstmid_first_byte got no ack within 20 cycles exp one");
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ram_req !== 1'b1 || ram_addr !== 32'h301 || ram_ack !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_access got req=%b addr=%h ack=%b exp 1 00000301 0", ram_req, ram_addr, ram_ack);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (ram_req !== 1'b0 || stallreq_mem !== 1'b0 || wb_wreg !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_idle got req=%b stall=%b wreg=%b exp 0 0 0", ram_req, stallreq_mem, wb_wreg);
      end
      n_vec++;
      if (mem[12'h300] !== 8'hD4 || mem[12'h301] !== 8'h00) begin
         n_err++;
         $display("FAIL rstmid_mem got %h %h exp d4 00", mem[12'h300], mem[12'h301]);
      end
      mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      test_reset();
      test_add();
      test_lw();
      test_extend();
      test_sh_wait();
      test_wrap();
      test_back_to_back();
      test_rst_mid();
      test_add();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
